// File: rtl/aes_seq_ctrl.sv
// aes_seq_ctrl: sequencer for the byte-serial AES datapath.
// It walks each block through LOAD, NR round passes, the output pipeline
// latency (WAIT) and the output shifter (OUT), and then pulses done.
// It also drives the key-expansion, round-core and feedback-mux enables.
// Optional feature: define AES_SEQ_CYCLE_CNT_EN to build the busy-cycle
// counter on cycle_cnt. Without it, cycle_cnt is tied to zero.
module aes_seq_ctrl #(
    parameter int NR        = 10,
    parameter int BLK_BYTES = 16,
    parameter int PIPE_LAT  = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         hold,
    input  logic                         abort,
    output logic                         busy,
    output logic                         in_ready,
    output logic [$clog2(BLK_BYTES)-1:0] byte_idx,
    output logic [$clog2(NR+1)-1:0]      round,
    output logic                         key_en,
    output logic                         core_en,
    output logic                         sel_fb,
    output logic                         last_round,
    output logic                         out_valid,
    output logic                         out_last,
    output logic                         done,
    output logic [15:0]                  cycle_cnt
);

    localparam int BW = $clog2(BLK_BYTES);
    localparam int RW = $clog2(NR + 1);
    localparam int WW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    localparam logic [BW-1:0] BYTE_LAST = BW'(BLK_BYTES - 1);
    localparam logic [RW-1:0] ROUND_MAX = RW'(NR);
    localparam logic [WW-1:0] WAIT_LAST = WW'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_WAIT,
        S_OUT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   byte_idx_q, byte_idx_d;
    logic [RW-1:0]   round_q, round_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic            mode_q, mode_d;
    logic            busy_q, busy_d;
    logic            in_ready_q, in_ready_d;
    logic            key_en_q, key_en_d;
    logic            core_en_q, core_en_d;
    logic            sel_fb_q, sel_fb_d;
    logic            last_round_q, last_round_d;
    logic            out_valid_q, out_valid_d;
    logic            out_last_q, out_last_d;
    logic            done_q, done_d;

    logic            stall;
    logic            pass_end;
    logic            final_pass;
    logic [RW-1:0]   round_step;

    // The last byte of a pass, the next round-key index in the block's direction, and whether the current pass is the final one.
    always_comb begin
        pass_end   = (byte_idx_q == BYTE_LAST);
        round_step = mode_q ? (round_q - 1'b1) : (round_q + 1'b1);
        final_pass = mode_q ? (round_q == '0) : (round_q == ROUND_MAX);
    end

    // Next state and counters, then registered decodes taken from that next state so they line up with it.
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        round_d    = round_q;
        wait_d     = wait_q;
        mode_d     = mode_q;
        stall      = 1'b0;

        if (state_q == S_IDLE) begin
            // hold has no effect in IDLE; start is always honoured here
            if (start) begin
                state_d    = S_LOAD;
                mode_d     = mode;
                round_d    = mode ? ROUND_MAX : '0;
                byte_idx_d = '0;
                wait_d     = '0;
            end
        end else if (abort) begin
            // abort leaves the round index alone; the next start reloads it
            state_d    = S_IDLE;
            byte_idx_d = '0;
            wait_d     = '0;
        end else if (hold) begin
            stall = 1'b1;
        end else begin
            case (state_q)
                S_LOAD: begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (pass_end) begin
                        state_d = S_ROUND;
                        round_d = round_step;
                    end
                end
                S_ROUND: begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (pass_end) begin
                        if (final_pass) begin
                            // round stays on its final index so it never leaves 0..NR
                            state_d = (PIPE_LAT == 0) ? S_OUT : S_WAIT;
                        end else begin
                            round_d = round_step;
                        end
                    end
                end
                S_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = S_OUT;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 1'b1;
                    end
                end
                S_OUT: begin
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (pass_end) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end

        busy_d       = (state_d != S_IDLE);
        in_ready_d   = (state_d == S_LOAD);
        core_en_d    = (state_d == S_LOAD) || (state_d == S_ROUND);
        key_en_d     = core_en_d && (byte_idx_d == '0);
        sel_fb_d     = (state_d == S_ROUND);
        last_round_d = (state_d == S_ROUND) &&
                       (mode_d ? (round_d == '0) : (round_d == ROUND_MAX));
        out_valid_d  = (state_d == S_OUT);
        out_last_d   = out_valid_d && (byte_idx_d == BYTE_LAST);
        done_d       = (state_d == S_DONE);

        // A stalled cycle repeats the frozen position with every strobe
        // low, so each byte is enabled exactly once however long the hold.
        if (stall) begin
            in_ready_d   = 1'b0;
            key_en_d     = 1'b0;
            core_en_d    = 1'b0;
            out_valid_d  = 1'b0;
            out_last_d   = 1'b0;
            done_d       = 1'b0;
            sel_fb_d     = sel_fb_q;
            last_round_d = last_round_q;
        end
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_idx_q   <= '0;
            round_q      <= '0;
            wait_q       <= '0;
            mode_q       <= 1'b0;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            key_en_q     <= 1'b0;
            core_en_q    <= 1'b0;
            sel_fb_q     <= 1'b0;
            last_round_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_idx_q   <= byte_idx_d;
            round_q      <= round_d;
            wait_q       <= wait_d;
            mode_q       <= mode_d;
            busy_q       <= busy_d;
            in_ready_q   <= in_ready_d;
            key_en_q     <= key_en_d;
            core_en_q    <= core_en_d;
            sel_fb_q     <= sel_fb_d;
            last_round_q <= last_round_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign in_ready   = in_ready_q;
    assign byte_idx   = byte_idx_q;
    assign round      = round_q;
    assign key_en     = key_en_q;
    assign core_en    = core_en_q;
    assign sel_fb     = sel_fb_q;
    assign last_round = last_round_q;
    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign done       = done_q;

`ifdef AES_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Busy-cycle count: cleared when a block is accepted, saturating, held through IDLE.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                cnt_d = '0;
            end
        end else if (cnt_q != 16'hFFFF) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    // Busy-cycle counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`else
    assign cycle_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_aes_seq_ctrl.sv
// Self-checking bench for aes_seq_ctrl.
// It runs a table of full blocks against an independent timeline model via a
// scoreboard, then hand-written abort/reset/start-held sequences, and one
// NR=14 / PIPE_LAT=0 instance.
module tb_aes_seq_ctrl;

    localparam int NR    = 10;
    localparam int B     = 16;
    localparam int PL    = 3;
    localparam int TOTAL = B * (NR + 2) + PL + 1;

`ifdef AES_SEQ_CYCLE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, mode, hold, abort;
    logic        busy, in_ready, key_en, core_en, sel_fb, last_round;
    logic        out_valid, out_last, done;
    logic [3:0]  byte_idx, round;
    logic [15:0] cycle_cnt;

    logic        start14;
    logic        mode14, hold14, abort14;
    logic        busy14, in_ready14, key_en14, core_en14, sel_fb14, last_round14;
    logic        out_valid14, out_last14, done14;
    logic [3:0]  byte_idx14, round14;
    logic [15:0] cycle_cnt14;

    aes_seq_ctrl #(.NR(NR), .BLK_BYTES(B), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .hold(hold), .abort(abort),
        .busy(busy), .in_ready(in_ready), .byte_idx(byte_idx), .round(round),
        .key_en(key_en), .core_en(core_en), .sel_fb(sel_fb), .last_round(last_round),
        .out_valid(out_valid), .out_last(out_last), .done(done), .cycle_cnt(cycle_cnt)
    );

    aes_seq_ctrl #(.NR(14), .BLK_BYTES(16), .PIPE_LAT(0)) dut14 (
        .clk(clk), .rst(rst), .start(start14), .mode(mode14), .hold(hold14), .abort(abort14),
        .busy(busy14), .in_ready(in_ready14), .byte_idx(byte_idx14), .round(round14),
        .key_en(key_en14), .core_en(core_en14), .sel_fb(sel_fb14), .last_round(last_round14),
        .out_valid(out_valid14), .out_last(out_last14), .done(done14), .cycle_cnt(cycle_cnt14)
    );

    typedef struct packed {
        logic       busy;
        logic       in_ready;
        logic [3:0] byte_idx;
        logic [3:0] round;
        logic       key_en;
        logic       core_en;
        logic       sel_fb;
        logic       last_round;
        logic       out_valid;
        logic       out_last;
        logic       done;
    } obs_t;

    obs_t act;
    assign act = {busy, in_ready, byte_idx, round, key_en, core_en, sel_fb,
                  last_round, out_valid, out_last, done};

    typedef struct {
        bit m;
        int hs;
        int hlen;
        int exp_busy;
        int exp_key;
        int exp_lr;
        int exp_ov;
        int exp_done;
    } vec_t;

    vec_t tbl[5];
    obs_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check_obs(input string name, input obs_t got, input obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s got=timeout want=event", name);
    endtask

    // Expected outputs at logical step s of a block (s counts advancing cycles).
    function automatic obs_t model(input int s, input bit stalled, input bit m);
        obs_t o;
        int   p;
        int   b;
        o      = '0;
        o.busy = 1'b1;
        if (s < B) begin
            o.in_ready = 1'b1;
            o.byte_idx = 4'(s);
            o.round    = m ? 4'(NR) : 4'd0;
            o.key_en   = (s == 0);
            o.core_en  = 1'b1;
        end else if (s < B * (NR + 1)) begin
            p            = (s - B) / B;
            b            = (s - B) % B;
            o.byte_idx   = 4'(b);
            o.round      = m ? 4'(NR - 1 - p) : 4'(p + 1);
            o.key_en     = (b == 0);
            o.core_en    = 1'b1;
            o.sel_fb     = 1'b1;
            o.last_round = (p == NR - 1);
        end else if (s < B * (NR + 1) + PL) begin
            o.round = m ? 4'd0 : 4'(NR);
        end else if (s < B * (NR + 2) + PL) begin
            b           = s - B * (NR + 1) - PL;
            o.byte_idx  = 4'(b);
            o.round     = m ? 4'd0 : 4'(NR);
            o.out_valid = 1'b1;
            o.out_last  = (b == B - 1);
        end else begin
            o.round = m ? 4'd0 : 4'(NR);
            o.done  = 1'b1;
        end
        if (stalled) begin
            o.in_ready  = 1'b0;
            o.key_en    = 1'b0;
            o.core_en   = 1'b0;
            o.out_valid = 1'b0;
            o.out_last  = 1'b0;
            o.done      = 1'b0;
        end
        return o;
    endfunction

    function automatic obs_t idle_exp(input bit m);
        obs_t o;
        o       = '0;
        o.round = m ? 4'd0 : 4'(NR);
        return o;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        obs_t exp;
        int   s, hcnt, nb, nk, nlr, ov, dn;
        bit   st, fin;
        v = tbl[idx];
        s = 0; hcnt = 0; nb = 0; nk = 0; nlr = 0; ov = -1; dn = -1;
        st = 1'b0; fin = 1'b0;
        mode  = v.m;
        start = 1'b1;
        hold  = 1'b0;
        abort = 1'b0;
        sb_q.push_back(model(0, 1'b0, v.m));
        for (int c = 0; c < TOTAL + 40 && !fin; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = sb_q.pop_front();
            check_obs($sformatf("vec%0d_cyc%0d", idx, c), act, exp);
            if (busy) nb++;
            if (key_en) nk++;
            if (last_round) nlr++;
            if (out_valid && ov < 0) ov = c;
            if (done) dn = c;
            hold = (s == v.hs) && (hcnt < v.hlen);
            if (hold) begin
                hcnt++;
                st = 1'b1;
            end else begin
                s++;
                st = 1'b0;
            end
            if (s == TOTAL) begin
                sb_q.push_back(idle_exp(v.m));
                fin = 1'b1;
            end else begin
                sb_q.push_back(model(s, st, v.m));
            end
        end
        hold = 1'b0;
        @(negedge clk);
        exp = sb_q.pop_front();
        check_obs($sformatf("vec%0d_idle", idx), act, exp);
        sb_q.delete();
        check_int($sformatf("vec%0d_busy_len", idx), nb, v.exp_busy);
        check_int($sformatf("vec%0d_key_en_cnt", idx), nk, v.exp_key);
        check_int($sformatf("vec%0d_last_round_cnt", idx), nlr, v.exp_lr);
        check_int($sformatf("vec%0d_out_start", idx), ov, v.exp_ov);
        check_int($sformatf("vec%0d_done_at", idx), dn, v.exp_done);
        check_int($sformatf("vec%0d_cycle_cnt", idx), int'(cycle_cnt), CNT_EN ? v.exp_busy : 0);
    endtask

    initial begin
        int  cnt, nir, nd, low, nk, nlr, ov, lastc, nl;
        bit  hit;
        obs_t zero;
        zero = '0;

        //            m  hold_step len busy key lr  ov   done
        tbl[0] = '{1'b0, -1,  0, 196, 11, 16, 179, 195};
        tbl[1] = '{1'b1, -1,  0, 196, 11, 16, 179, 195};
        tbl[2] = '{1'b0, 55,  5, 201, 11, 16, 184, 200};   // round 3, byte 7
        tbl[3] = '{1'b1, 80,  3, 199, 11, 16, 182, 198};   // decrypt round 5, byte 0
        tbl[4] = '{1'b0, 194, 2, 198, 11, 16, 179, 197};   // OUT byte 15

        rst = 1'b1; start = 1'b0; mode = 1'b0; hold = 1'b0; abort = 1'b0;
        start14 = 1'b0; mode14 = 1'b0; hold14 = 1'b0; abort14 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_obs("reset_state", act, zero);
        check_int("reset_cycle_cnt", int'(cycle_cnt), 0);
        check_int("reset_busy14", int'(busy14), 0);

        for (int i = 0; i < 5; i++) begin
            run_vec(i);
        end

        // abort during OUT byte 4, then restart one cycle later
        mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (out_valid && byte_idx == 4'd4) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) timeout_fail("abort_wait_out4");
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_obs("abort_to_idle", act, idle_exp(1'b0));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_obs("restart_clean_load", act, model(0, 1'b0, 1'b0));

        // reset mid-ROUND together with hold and abort
        hit = 1'b0;
        for (int c = 0; c < 300 && !hit; c++) begin
            if (sel_fb && round == 4'd5) hit = 1'b1;
            else @(negedge clk);
        end
        if (!hit) timeout_fail("rst_wait_round5");
        rst = 1'b1; hold = 1'b1; abort = 1'b1;
        @(negedge clk);
        rst = 1'b0; hold = 1'b0; abort = 1'b0;
        check_obs("rst_mid_round", act, zero);
        check_int("rst_mid_round_cnt", int'(cycle_cnt), 0);

        // start held high for a whole block: no restart before DONE
        start = 1'b1; mode = 1'b0;
        cnt = 0; nir = 0; nd = 0; low = 0; hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (in_ready) nir++;
                if (done) nd++;
            end else begin
                hit = 1'b1;
            end
        end
        if (!hit) timeout_fail("start_held_busy_drop");
        hit = 1'b0;
        for (int c = 0; c < 5 && !hit; c++) begin
            if (busy) hit = 1'b1;
            else begin
                low++;
                @(negedge clk);
            end
        end
        check_int("start_held_busy_len", cnt, 196);
        check_int("start_held_in_ready_cnt", nir, 16);
        check_int("start_held_done_cnt", nd, 1);
        check_int("start_held_idle_gap", low, 1);
        start = 1'b0; abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        @(negedge clk);
        check_int("start_held_cleanup_busy", int'(busy), 0);

        // NR=14, PIPE_LAT=0 instance
        start14 = 1'b1;
        @(negedge clk);
        start14 = 1'b0;
        cnt = 0; nk = 0; nlr = 0; ov = -1; lastc = -1; nir = 0; nl = 0; nd = -1; hit = 1'b0;
        for (int c = 0; c < 400 && !hit; c++) begin
            if (busy14) begin
                cnt++;
                if (key_en14) nk++;
                if (in_ready14) nir++;
                if (last_round14) begin
                    nlr++;
                    check_int($sformatf("nr14_last_round_idx_c%0d", c), int'(round14), 14);
                end
                if (sel_fb14 && core_en14) lastc = c;
                if (out_valid14 && ov < 0) ov = c;
                if (out_last14) begin
                    nl++;
                    check_int("nr14_out_last_byte", int'(byte_idx14), 15);
                end
                if (done14) nd = c;
                @(negedge clk);
            end else begin
                hit = 1'b1;
            end
        end
        if (!hit) timeout_fail("nr14_busy_drop");
        check_int("nr14_busy_len", cnt, 257);
        check_int("nr14_key_en_cnt", nk, 15);
        check_int("nr14_in_ready_cnt", nir, 16);
        check_int("nr14_last_round_cnt", nlr, 16);
        check_int("nr14_out_start", ov, 240);
        check_int("nr14_no_wait_gap", ov - lastc, 1);
        check_int("nr14_out_last_cnt", nl, 1);
        check_int("nr14_done_at", nd, 256);
        check_int("nr14_cycle_cnt", int'(cycle_cnt14), CNT_EN ? 257 : 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/aes_seq_ctrl.md
Name: aes_seq_ctrl

Overview:
- Parametrised sequencer for the byte-serial AES datapath: key expansion, round core, feedback mux and output shifter.
- Replaces fixed hard-coded counter decoding with an explicit FSM, and generalises to any round count (10/12/14) and block length.
- Supports encrypt and decrypt round ordering, a stall input (hold), an abort input, and a start/busy/done handshake.
- Sits between the top-level byte interface and the key_exp/encrypt/decrypt cores, and drives all of their enables.

Parameters:
- NR, 10, number of AES rounds (10, 12 or 14).
- BLK_BYTES, 16, bytes per block; power of two, ≥2.
- PIPE_LAT, 3, cycles between the last round byte and the first valid output byte; ≥0.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a block; sampled only in IDLE.
- mode  in  1  0 = encrypt, 1 = decrypt; latched with start.
- hold  in  1  stall; freezes all counters and state.
- abort  in  1  cancel the current block.
- busy  out  1  high in every state except IDLE.
- in_ready  out  1  input byte accepted this cycle.
- byte_idx  out  $clog2(BLK_BYTES)  byte position within the current pass.
- round  out  $clog2(NR+1)  current round-key index.
- key_en  out  1  one-cycle request for the next round-key pass.
- core_en  out  1  round core enable.
- sel_fb  out  1  0 = core fed from input, 1 = core fed from its own output.
- last_round  out  1  final round active (datapath skips MixColumns).
- out_valid  out  1  output byte valid.
- out_last  out  1  final output byte.
- done  out  1  one-cycle completion pulse.
- cycle_cnt  out  16  busy-cycle count (optional feature).

Behaviour:
- Reset values: all outputs 0; state IDLE; round 0; latched mode 0.
- FSM states: IDLE, LOAD, ROUND, WAIT, OUT, DONE.
- IDLE:
  - start=1 → LOAD on the next cycle.
  - Latch mode. round ← 0 for encrypt, NR for decrypt. byte_idx ← 0.
  - start while not IDLE is ignored.
- LOAD: BLK_BYTES cycles; in_ready=1, core_en=1, sel_fb=0.
- ROUND:
  - NR passes of BLK_BYTES cycles each; core_en=1, sel_fb=1.
  - Encrypt: round runs 1..NR. Decrypt: round runs NR-1..0.
  - round steps on the same edge where byte_idx wraps BLK_BYTES-1→0, including the LOAD→ROUND transition.
- key_en: 1 when byte_idx==0 in LOAD or ROUND and hold=0.
- last_round: 1 in ROUND while round==NR (encrypt) or round==0 (decrypt).
- WAIT: PIPE_LAT cycles with all enables 0. When PIPE_LAT=0, WAIT is skipped.
- OUT:
  - BLK_BYTES cycles; out_valid=1 and byte_idx counts 0..BLK_BYTES-1.
  - out_last=1 when byte_idx==BLK_BYTES-1.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- Busy length without stalls: BLK_BYTES·(NR+2)+PIPE_LAT+1 cycles. Defaults give 196.
- Decoded outputs (in_ready, key_en, core_en, out_valid, out_last, done) are registered. They are valid in the same cycle as the state and byte_idx they decode.
- hold=1:
  - State, byte_idx and round are frozen.
  - in_ready, key_en, core_en, out_valid, out_last are forced 0 for that cycle.
  - sel_fb, round, byte_idx and last_round keep their values.
  - hold in IDLE has no effect, and start is still accepted.
- abort=1 in any non-IDLE state: next cycle IDLE, busy=0, done not pulsed, all enables 0.
- Priority: rst > abort > hold > normal sequencing.
- byte_idx wraps modulo BLK_BYTES. round never leaves 0..NR.

Optional Feature:
- Macro AES_SEQ_CYCLE_CNT_EN.
- Defined:
  - cycle_cnt clears to 0 on start acceptance and increments every busy cycle, including hold cycles.
  - It saturates at 16'hFFFF and holds its final value in IDLE until the next start.
  - rst clears it.
- Not defined: cycle_cnt tied to 16'h0000; no counter logic.

Test Plan:
- Defaults, encrypt: mode=0, start pulse → busy for 196 cycles.
  - key_en pulses 11 times, 16 cycles apart; round runs 0,1..10.
  - last_round high for 16 cycles at round 10.
  - out_valid for 16 cycles starting 179 cycles after busy rises; done at busy cycle 196.
- Defaults, decrypt: mode=1 → round runs 10,9..0; last_round high during the round=0 pass; same timing as encrypt.
- NR=14, BLK_BYTES=16, PIPE_LAT=0 → 257 busy cycles; no WAIT cycles; out_valid directly follows the last ROUND byte.
- hold high for 5 cycles in ROUND at byte_idx=7, round=3 → byte_idx/round frozen at 7/3, core_en=0; busy extends to 201 cycles; with AES_SEQ_CYCLE_CNT_EN, cycle_cnt=201.
- abort at OUT byte 4 → IDLE next cycle, no done pulse, out_valid=0. A start 1 cycle later begins a clean LOAD with byte_idx=0.
- rst asserted mid-ROUND together with hold and abort → all outputs 0 the next cycle. start held high throughout a block → no restart until after DONE.
